// File: rtl/ierl78_ice_pkg.sv
// ierl78_ice_pkg: shared ICE bus constants and arbiter FSM state type
package ierl78_ice_pkg;
  localparam int ICEDOP_W = 32;
  localparam int MAX_NREQ = 8;
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/ierl78_icedop_arb_if.sv
// ierl78_icedop_arb_if: requester/host side of the ICEDOP arbiter
interface ierl78_icedop_arb_if
  import ierl78_ice_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = ICEDOP_W
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      icedop;
  logic               dopvld;
  logic [2:0]         dopsrc;
  logic               dopack;
  logic               toerr;
  logic               busy;
  modport master (output req, din, dopack, input gnt, icedop, dopvld, dopsrc, toerr, busy);
  modport slave  (input req, din, dopack, output gnt, icedop, dopvld, dopsrc, toerr, busy);
endinterface

// File: rtl/ierl78_icedop_arb_rr_pick.sv
// ierl78_rr_pick: round-robin winner search upward from ptr, wrapping mod N
module ierl78_rr_pick #(
  parameter int N  = 2,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  hot,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) idx = PW'((int'(ptr) + k) % N);
    any = |req;
    hot = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/ierl78_icedop_arb.sv
// ierl78_icedop_arb: round-robin arbiter and holding register for the ICEDOP read-out bus
module ierl78_icedop_arb
  import ierl78_ice_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int DW       = ICEDOP_W,
  parameter int TOUT_CYC = 255,
  parameter int TW       = 8
) (
  input logic clk,
  input logic resetb,
  ierl78_icedop_arb_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam logic [TW-1:0] TLAST = TW'(TOUT_CYC == 0 ? 0 : TOUT_CYC - 1);
  state_t          st, st_nxt;
  logic [PW-1:0]   ptr, src, idx;
  logic [NREQ-1:0] hot, gnt;
  logic            any, ack_rel, to_rel, toerr, take;
  logic [DW-1:0]   data;
  logic [TW-1:0]   cnt;
  ierl78_rr_pick #(.N(NREQ)) u_pick (.req(bus.req), .ptr, .hot, .idx, .any);
  always_comb begin
    take    = st == ST_IDLE && any;
    ack_rel = st == ST_HOLD && bus.dopack;
    to_rel  = st == ST_HOLD && !bus.dopack && TOUT_CYC != 0 && cnt == TLAST;
    st_nxt  = st == ST_IDLE ? (any ? ST_HOLD : ST_IDLE) : (ack_rel || to_rel ? ST_IDLE : ST_HOLD);
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) st <= ST_IDLE;
    else st <= st_nxt;
  // data/src are cleared on release so the bus stays OR-compatible while idle
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      ptr   <= '0;
      src   <= '0;
      data  <= '0;
      cnt   <= '0;
      gnt   <= '0;
      toerr <= 1'b0;
    end else begin
      gnt   <= take ? hot : '0;
      toerr <= to_rel;
      if (take) begin
        data <= bus.din[idx*DW +: DW];
        src  <= idx;
        ptr  <= idx == PW'(NREQ - 1) ? '0 : idx + 1'b1;
        cnt  <= '0;
      end else if (ack_rel || to_rel) begin
        data <= '0;
        src  <= '0;
      end else if (st == ST_HOLD) cnt <= cnt + 1'b1;
    end
  assign bus.gnt    = gnt;
  assign bus.icedop = data;
  assign bus.dopvld = st == ST_HOLD;
  assign bus.dopsrc = 3'(src);
  assign bus.toerr  = toerr;
  assign bus.busy   = st != ST_IDLE;
endmodule

// File: tb/tb_ierl78_icedop_arb.sv
// tb_ierl78_icedop_arb: directed scoreboard bench for 2- and 3-requester arbiters
module tb_ierl78_icedop_arb;
  logic clk = 1'b0;
  logic resetb;
  int errors = 0;
  int checks = 0;
  logic [42:0] q[$];
  ierl78_icedop_arb_if #(.NREQ(2)) a ();
  ierl78_icedop_arb_if #(.NREQ(3)) b ();
  ierl78_icedop_arb #(.NREQ(2), .TOUT_CYC(4)) dut_a (.clk(clk), .resetb(resetb), .bus(a));
  ierl78_icedop_arb #(.NREQ(3), .TOUT_CYC(4)) dut_b (.clk(clk), .resetb(resetb), .bus(b));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [42:0] ex(input logic [7:0] g, input logic [2:0] s, input logic [31:0] d);
    return {g, s, d};
  endfunction
  task automatic wait_grant(input bit s, input string tag);
    int n = 0;
    logic [42:0] exp;
    do begin
      tick();
      n++;
    end while ((s ? 32'(b.gnt) : 32'(a.gnt)) == 0 && n < 8);
    exp = q.size() > 0 ? q.pop_front() : 'x;
    chk(tag, s ? {8'(b.gnt), b.dopsrc, b.icedop} : {8'(a.gnt), a.dopsrc, a.icedop}, 64'(exp));
  endtask
  task automatic do_reset();
    @(negedge clk) resetb = 1'b0;
    @(negedge clk) resetb = 1'b1;
  endtask
  initial begin
    int hi, te, g;
    resetb = 1'b0;
    a.req = '0; a.din = '0; a.dopack = 1'b0;
    b.req = '0; b.din = '0; b.dopack = 1'b0;
    #2;
    chk("reset_out", {32'(a.gnt), a.icedop, a.dopvld, a.dopsrc, a.toerr, a.busy}, 64'd0);
    @(negedge clk) resetb = 1'b1;
    tick();
    chk("idle_no_req", {a.busy, a.dopvld, 2'(a.gnt)}, 64'd0);
    // single transfer with ack
    a.req = 2'b01; a.din[31:0] = 32'hA5A5_0001;
    q.push_back(ex(8'b01, 3'd0, 32'hA5A5_0001));
    wait_grant(0, "first_grant");
    a.req = 2'b00;
    tick();
    chk("gnt_one_cycle", {a.gnt, a.dopvld, a.icedop}, {2'b00, 1'b1, 32'hA5A5_0001});
    a.dopack = 1'b1;
    tick();
    a.dopack = 1'b0;
    chk("ack_release", {a.dopvld, a.icedop, a.dopsrc, a.busy}, 64'd0);
    // continuous requests, ack every hold cycle
    do_reset();
    a.req = 2'b11; a.din[31:0] = 32'd1; a.din[63:32] = 32'd2; a.dopack = 1'b1;
    for (int i = 0; i < 4; i++) q.push_back(i % 2 == 0 ? ex(8'b01, 3'd0, 32'd1) : ex(8'b10, 3'd1, 32'd2));
    for (int i = 0; i < 4; i++) begin
      wait_grant(0, "rr_alt");
      tick();
      chk("rr_idle_gap", {a.dopvld, a.busy, a.gnt}, 64'd0);
    end
    a.req = 2'b00; a.dopack = 1'b0;
    tick();
    // timeout release
    a.din[31:0] = 32'h0000_0777;
    a.req = 2'b01;
    q.push_back(ex(8'b01, 3'd0, 32'h0000_0777));
    wait_grant(0, "to_grant");
    a.req = 2'b00;
    hi = 1; te = 0;
    repeat (6) begin
      tick();
      if (a.dopvld) hi++;
      te += int'(a.toerr);
    end
    chk("to_vld_cycles", 64'(hi), 64'd4);
    chk("to_toerr_once", 64'(te), 64'd1);
    chk("to_idle", {a.busy, a.icedop}, 64'd0);
    // ack on the last hold cycle beats the timeout
    a.req = 2'b01;
    q.push_back(ex(8'b01, 3'd0, 32'h0000_0777));
    wait_grant(0, "to_ack_grant");
    a.req = 2'b00;
    repeat (3) tick();
    chk("to_still_hold", 64'(a.dopvld), 64'd1);
    a.dopack = 1'b1;
    tick();
    a.dopack = 1'b0;
    chk("to_ack_wins", {a.toerr, a.dopvld}, 64'd0);
    tick();
    chk("to_ack_no_late_toerr", 64'(a.toerr), 64'd0);
    // async reset mid-hold
    a.req = 2'b10; a.din[63:32] = 32'hDEAD_BEEF;
    q.push_back(ex(8'b10, 3'd1, 32'hDEAD_BEEF));
    wait_grant(0, "rst_grant");
    a.req = 2'b00;
    tick();
    chk("rst_hold_word", 64'(a.icedop), 64'hDEAD_BEEF);
    #2 resetb = 1'b0;
    #1;
    chk("rst_async_clear", {a.icedop, a.dopvld, a.dopsrc, a.gnt, a.toerr, a.busy}, 64'd0);
    @(negedge clk) resetb = 1'b1;
    a.req = 2'b11; a.din[31:0] = 32'h0000_0100;
    q.push_back(ex(8'b01, 3'd0, 32'h0000_0100));
    wait_grant(0, "rst_ptr_zero");
    a.req = 2'b00; a.dopack = 1'b1;
    tick();
    a.dopack = 1'b0;
    // short req0 pulse during another source's hold is ignored
    a.req = 2'b10; a.din[63:32] = 32'h0000_1111;
    q.push_back(ex(8'b10, 3'd1, 32'h0000_1111));
    wait_grant(0, "pulse_grant1");
    a.req = 2'b01;
    tick();
    a.req = 2'b00; a.dopack = 1'b1;
    tick();
    a.dopack = 1'b0;
    g = 0;
    repeat (4) begin
      tick();
      g += int'(|a.gnt);
    end
    chk("pulse_no_grant", 64'(g), 64'd0);
    a.dopack = 1'b1;
    tick();
    a.dopack = 1'b0;
    chk("ack_in_idle", {a.busy, a.dopvld, a.toerr, a.gnt}, 64'd0);
    a.req = 2'b11;
    q.push_back(ex(8'b01, 3'd0, 32'h0000_0100));
    wait_grant(0, "ptr_after_pulse");
    a.req = 2'b00; a.dopack = 1'b1;
    tick();
    a.dopack = 1'b0;
    // three requesters
    b.din[31:0] = 32'h0000_00B0; b.din[95:64] = 32'h0000_00B2;
    b.req = 3'b100;
    q.push_back(ex(8'b100, 3'd2, 32'h0000_00B2));
    wait_grant(1, "n3_first2");
    b.req = 3'b000; b.dopack = 1'b1;
    tick();
    b.dopack = 1'b0;
    b.req = 3'b101;
    q.push_back(ex(8'b001, 3'd0, 32'h0000_00B0));
    q.push_back(ex(8'b100, 3'd2, 32'h0000_00B2));
    wait_grant(1, "n3_wrap0");
    b.req = 3'b100; b.dopack = 1'b1;
    tick();
    b.dopack = 1'b0;
    wait_grant(1, "n3_then2");
    b.req = 3'b000; b.dopack = 1'b1;
    tick();
    b.dopack = 1'b0;
    chk("n3_idle", {b.busy, b.dopvld, b.dopsrc, b.icedop}, 64'd0);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
